// File: rtl/utils_pkg.sv
// rtl/utils_pkg.sv - shared arithmetic types and helpers for the utils datapath blocks
package utils_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;

  // Two's-complement magnitude / conditional negate; callers slice the low bits they need.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value, input logic negate);
    return negate ? -value : value;
  endfunction

endpackage

// File: rtl/fast_adder.sv
// rtl/fast_adder.sv - block carry-lookahead adder, ripple inside each group
module fast_adder #(
  parameter int word_width   = 16,
  parameter int cascade_size = 4
) (
  input  logic [word_width-1:0] i_a,
  input  logic [word_width-1:0] i_b,
  input  logic                  i_cin,
  output logic [word_width-1:0] o_sum,
  output logic                  o_cout
);

  localparam int NG = (word_width + cascade_size - 1) / cascade_size;

  logic [word_width-1:0] w_gen;
  logic [word_width-1:0] w_prop;
  logic [NG:0]           w_gcarry;

  assign w_gen       = i_a & i_b;
  assign w_prop      = i_a ^ i_b;
  assign w_gcarry[0] = i_cin;
  assign o_cout      = w_gcarry[NG];

  for (genvar g = 0; g < NG; g++) begin : g_grp
    localparam int LO = g * cascade_size;
    localparam int HI = (LO + cascade_size < word_width) ? LO + cascade_size : word_width;
    localparam int GW = HI - LO;

    logic [GW-1:0] w_c;
    logic [GW:0]   w_gc;
    logic          w_gp;

    assign w_c[0]  = w_gcarry[g];
    assign w_gc[0] = 1'b0;
    assign w_gp    = &w_prop[HI-1:LO];

    for (genvar k = 0; k < GW; k++) begin : g_bit
      assign o_sum[LO+k] = w_prop[LO+k] ^ w_c[k];
      assign w_gc[k+1]   = w_gen[LO+k] | (w_prop[LO+k] & w_gc[k]);
      if (k > 0) begin : g_rip
        assign w_c[k] = w_gen[LO+k-1] | (w_prop[LO+k-1] & w_c[k-1]);
      end
    end

    // Group carry skips straight across using group generate/propagate.
    assign w_gcarry[g+1] = w_gc[GW] | (w_gp & w_gcarry[g]);
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring divider, signed or unsigned per transaction
module seq_divider #(
  parameter int WORD_WIDTH   = 16,
  parameter int CASCADE_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [WORD_WIDTH-1:0] dividend,
  input  logic [WORD_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] quotient,
  output logic [WORD_WIDTH-1:0] remainder,
  output logic                  div_zero
);

  import utils_pkg::*;

  localparam int W     = WORD_WIDTH;
  localparam int CNT_W = $clog2(WORD_WIDTH + 1);

  div_state_t       r_state;
  logic [W:0]       r_prem;
  logic [W-1:0]     r_dvd;
  logic [W-1:0]     r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [W-1:0]     r_quotient;
  logic [W-1:0]     r_remainder;
  logic             r_div_zero;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [MAX_W-1:0] w_dvd_full;
  logic [MAX_W-1:0] w_dvs_full;
  logic [MAX_W-1:0] w_q_full;
  logic [MAX_W-1:0] w_r_full;
  logic [W:0]       w_shift;
  logic [W:0]       w_diff;
  logic             w_no_borrow;
  logic             w_unused;

  assign w_dvd_neg  = in_signed & dividend[W-1];
  assign w_dvs_neg  = in_signed & divisor[W-1];
  assign w_dvd_full = abs_w(MAX_W'(dividend), w_dvd_neg);
  assign w_dvs_full = abs_w(MAX_W'(divisor), w_dvs_neg);
  assign w_q_full   = abs_w(MAX_W'(r_dvd), r_neg_q);
  assign w_r_full   = abs_w(MAX_W'(r_prem[W-1:0]), r_neg_r);

  // The remainder never exceeds the divisor, so r_prem[W] is only headroom for the shift.
  assign w_shift  = {r_prem[W-1:0], r_dvd[W-1]};
  assign w_unused = ^{r_prem[W], w_dvd_full, w_dvs_full, w_q_full, w_r_full};

  fast_adder #(
    .word_width  (W + 1),
    .cascade_size(CASCADE_SIZE)
  ) u_trial_sub (
    .i_a   (w_shift),
    .i_b   (~{1'b0, r_dvs}),
    .i_cin (1'b1),
    .o_sum (w_diff),
    .o_cout(w_no_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_prem      <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r    <= w_dvd_neg;
            r_prem     <= '0;
            r_cnt      <= '0;
            r_dvs      <= w_dvs_full[W-1:0];
            r_in_ready <= 1'b0;
            if (divisor == '0) begin
              r_dz    <= 1'b1;
              r_dvd   <= dividend;
              r_state <= FIX;
            end else begin
              r_dz    <= 1'b0;
              r_dvd   <= w_dvd_full[W-1:0];
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_prem <= w_no_borrow ? w_diff : w_shift;
          r_dvd  <= {r_dvd[W-2:0], w_no_borrow};
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(W - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_out_valid <= 1'b1;
          r_div_zero  <= r_dz;
          if (r_dz) begin
            r_quotient  <= '1;
            r_remainder <= r_dvd;
          end else begin
            r_quotient  <= w_q_full[W-1:0];
            r_remainder <= w_r_full[W-1:0];
          end
          r_state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider at WORD_WIDTH=8
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider #(.WORD_WIDTH(W), .CASCADE_SIZE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_signed(in_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: C-style truncating division on plain integers.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int sa, sb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q = W'(sa / sb);
      r = W'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  task automatic start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_signed = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic txn(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic edz;
    model(s, a, b, eq, er, edz);
    start(s, a, b);
    wait_result(tag, edz ? 1 : W + 1);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, div_zero, edz);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, out_valid, 0);
    check({tag, "_rdy_back"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, bq, br;
    logic rs, bdz;

    #2;
    check("rst_ov", out_valid, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_zero, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rdy", in_ready, 1);

    txn("u100_7", 1'b0, 8'd100, 8'd7);
    txn("s_m100_7", 1'b1, 8'h9C, 8'd7);
    txn("s_ovf", 1'b1, 8'h80, 8'hFF);
    txn("u_dz", 1'b0, 8'd55, 8'd0);
    txn("s_dz", 1'b1, 8'd55, 8'd0);
    txn("u_max", 1'b0, 8'hFF, 8'h01);
    txn("s_neg_neg", 1'b1, 8'hF9, 8'hFE);

    for (int i = 0; i < 40; i++) begin
      rs = 1'(($urandom % 2));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      txn("rand", rs, ra, rb);
    end

    // Backpressure: result held while new operands are waved at the idle-less divider.
    model(1'b0, 8'd100, 8'd7, bq, br, bdz);
    start(1'b0, 8'd100, 8'd7);
    wait_result("bp", W + 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk); #1;
      check("bp_ov", out_valid, 1);
      check("bp_rdy", in_ready, 0);
      check("bp_q", quotient, bq);
      check("bp_r", remainder, br);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_ov_clr", out_valid, 0);
    check("bp_rdy_back", in_ready, 1);
    check("bp_q_hold", quotient, bq);
    check("bp_r_hold", remainder, br);
    @(posedge clk); #1;
    check("bp_no_capture", in_ready, 1);

    // Asynchronous reset in the middle of the iteration.
    start(1'b0, 8'd250, 8'd5);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_ov", out_valid, 0);
    check("mrst_q", quotient, 0);
    check("mrst_r", remainder, 0);
    check("mrst_dz", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    txn("after_rst", 1'b0, 8'd200, 8'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider, unsigned or signed per transaction, parametrised word width.
- Sequential successor to the combinational utils arithmetic (fast_adder, fast_comparator). One quotient bit per clock, with valid/ready handshakes on input and output.
- Sits beside the utils arithmetic as the shared divide resource for datapaths that cannot afford a combinational divider.

Parameters:
- WORD_WIDTH, 16, dividend/divisor/quotient/remainder width in bits (>=2, multiple of CASCADE_SIZE)
- CASCADE_SIZE, 4, carry-lookahead group size passed to the internal fast_adder instance

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  divider idle, can accept
- in_signed  in  1  1 = two's-complement operation, 0 = unsigned
- dividend  in  WORD_WIDTH  numerator
- divisor  in  WORD_WIDTH  denominator
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- quotient  out  WORD_WIDTH  result quotient
- remainder  out  WORD_WIDTH  result remainder
- div_zero  out  1  divisor was zero for this result

Behaviour:
- Reset (asynchronous, rst_n=0, any state): state=IDLE; in_ready=1 after release; out_valid=0, quotient=0, remainder=0, div_zero=0; iteration counter=0. Reset mid-operation discards the transaction silently.
- States:
  - IDLE: in_ready=1. Accept on in_valid&in_ready at rising edge t.
    - Latch sign flags (signed mode: neg_q=sign(dividend)^sign(divisor), neg_r=sign(dividend)).
    - Latch magnitudes: absolute values in signed mode, raw values in unsigned mode.
    - Zero partial remainder and counter.
    - Next state: RUN, or FIX with dz=1 if divisor==0.
  - RUN: each edge shift {prem,dvd} left 1, trial-subtract divisor via fast_adder (a + ~b + 1).
    - If no borrow, keep the difference and set q bit=1; otherwise restore and set q bit=0.
    - Counter increments. After WORD_WIDTH iterations: next state FIX.
  - FIX: apply sign correction in signed mode (negate quotient if neg_q, negate remainder if neg_r). Drive outputs, out_valid←1. Next state: DONE.
  - DONE: outputs stable while out_valid=1. On out_valid&out_ready at an edge: out_valid←0, state←IDLE.
- Latency from the accepting edge t:
  - normal: out_valid visible after edge t+WORD_WIDTH+1
  - divide by zero: out_valid visible after edge t+1
- Throughput: one transaction at a time. in_ready=0 in RUN, FIX and DONE. in_valid is ignored there; no operand capture.
- Divide by zero: quotient=all ones, remainder=dividend (original, unsigned interpretation irrelevant), div_zero=1. Not sign-corrected.
- Signed overflow (MIN / -1): quotient=MIN, remainder=0, div_zero=0 (wrap, no flag). This falls out of magnitude arithmetic and must not be special-cased differently.
- Unsigned mode: in_signed=0 treats MSB as magnitude; no correction in FIX.
- Outputs are registered. Quotient/remainder hold their last values after the DONE→IDLE handshake. They are not cleared, and are valid only while out_valid=1.
- Width rule: partial remainder register WORD_WIDTH+1 bits, so the trial subtraction never loses the borrow.

Decomposition:
- utils_pkg:
  - div_state_t enum {IDLE, RUN, FIX, DONE}
  - function abs_w for magnitude and conditional negate
- Counter width localparam $clog2(WORD_WIDTH+1), computed in the module from the parameter.
- One sub-module: existing fast_adder (word_width=WORD_WIDTH+1, cascade_size=CASCADE_SIZE) for the trial subtract. No new sub-module.

Test Plan:
- WORD_WIDTH=8.
  - Unsigned: dividend=100, divisor=7, in_signed=0 → quotient=14, remainder=2, div_zero=0; out_valid first seen after edge t+9.
  - Signed: dividend=-100 (0x9C), divisor=7 → quotient=0xF2 (-14), remainder=0xFE (-2).
  - Signed overflow: 0x80 / 0xFF → quotient=0x80, remainder=0x00, div_zero=0.
  - Divide by zero: 55/0, either mode → quotient=0xFF, remainder=55, div_zero=1; out_valid after edge t+1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid with new operands.
  - Outputs and out_valid stay stable; in_ready=0; no new capture.
  - out_ready=1 → IDLE next edge, in_ready=1.
- Reset mid-RUN: assert rst_n=0 at iteration 4 → out_valid=0, outputs 0 immediately (async); after release a fresh 200/3 unsigned → quotient=66, remainder=2.
